// File: rtl/msf_frame_decoder.sv
// MSF minute-frame decoder: collects 59 data seconds, validates the frame, strobes out BCD time.
// Optional date outputs and checks are enabled by defining MSF_DATE_EN.
module msf_frame_decoder #(
  parameter int SYNC_FRAMES = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sec_valid_i,
  input  logic       marker_i,
  input  logic       bit_a_i,
  input  logic       bit_b_i,
  output logic       load_o,
  output logic [3:0] min_units_o,
  output logic [2:0] min_tens_o,
  output logic [3:0] hour_units_o,
  output logic [1:0] hour_tens_o,
  output logic       frame_err_o,
  output logic       synced_o
`ifdef MSF_DATE_EN
  ,
  output logic [7:0] year_o,
  output logic [4:0] month_o,
  output logic [5:0] day_o,
  output logic [2:0] weekday_o
`endif
);

  typedef enum logic {S_HUNT, S_COLLECT} state_t;

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_idx, w_idx_nxt;
  logic [58:0] r_sr;  // A1 lands in bit 58, A59 in bit 0
  logic        r_b57;
  logic [2:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic        w_load_nxt, w_err_nxt, w_synced_nxt, w_shift, w_met;
  logic [1:0]  w_ht;
  logic [3:0]  w_hu;
  logic [2:0]  w_mt;
  logic [3:0]  w_mu;
  logic        w_id_ok, w_time_ok, w_par_ok, w_date_ok, w_frame_ok;

  assign w_ht      = r_sr[20:19];
  assign w_hu      = r_sr[18:15];
  assign w_mt      = r_sr[14:12];
  assign w_mu      = r_sr[11:8];
  assign w_id_ok   = (r_sr[7:0] == 8'b0111_1110);
  assign w_par_ok  = ^{r_sr[20:8], r_b57};
  assign w_time_ok = (w_hu <= 4'd9) && (w_mt <= 3'd5) && (w_mu <= 4'd9) &&
                     ((w_ht < 2'd2) || ((w_ht == 2'd2) && (w_hu <= 4'd3)));

`ifdef MSF_DATE_EN
  logic [2:0] r_b_date;  // B54..B56
  logic [7:0] w_yr;
  logic [4:0] w_mo;
  logic [5:0] w_dy;
  logic [2:0] w_wd;
  logic       w_unused;
  assign w_yr = r_sr[42:35];
  assign w_mo = r_sr[34:30];
  assign w_dy = r_sr[29:24];
  assign w_wd = r_sr[23:21];
  assign w_unused = &{1'b0, r_sr[58:43]};
  assign w_date_ok = (^{r_sr[42:35], r_b_date[0]}) && (^{r_sr[34:24], r_b_date[1]}) &&
                     (^{r_sr[23:21], r_b_date[2]}) &&
                     (w_yr[7:4] <= 4'd9) && (w_yr[3:0] <= 4'd9) &&
                     (w_mo[3:0] <= 4'd9) && (w_mo != 5'd0) && (!w_mo[4] || (w_mo[3:0] <= 4'd2)) &&
                     (w_dy[3:0] <= 4'd9) && (w_dy != 6'd0) && ((w_dy[5:4] != 2'd3) || (w_dy[3:0] <= 4'd1)) &&
                     (w_wd <= 3'd6);
`else
  logic w_unused;
  assign w_unused  = &{1'b0, r_sr[58:21]};
  assign w_date_ok = 1'b1;
`endif

  assign w_frame_ok = (r_idx == 6'd59) && w_id_ok && w_par_ok && w_time_ok && w_date_ok;
  assign w_cnt_inc  = (r_cnt == 3'd7) ? 3'd7 : r_cnt + 3'd1;
  assign w_met      = (w_cnt_inc >= 3'(SYNC_FRAMES));

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_cnt_nxt    = r_cnt;
    w_synced_nxt = synced_o;
    w_load_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_shift      = 1'b0;
    if (sec_valid_i) begin
      if (marker_i) begin
        w_state_nxt = S_COLLECT;
        w_idx_nxt   = 6'd0;
        if (r_state == S_COLLECT) begin
          if (w_frame_ok) begin
            w_cnt_nxt    = w_cnt_inc;
            w_synced_nxt = w_met;
            w_load_nxt   = w_met;
          end else begin
            w_err_nxt    = 1'b1;
            w_cnt_nxt    = 3'd0;
            w_synced_nxt = 1'b0;
          end
        end
      end else if (r_state == S_COLLECT) begin
        // A 60th data second means the marker was missed: resynchronise from scratch.
        if (r_idx == 6'd59) begin
          w_err_nxt    = 1'b1;
          w_cnt_nxt    = 3'd0;
          w_synced_nxt = 1'b0;
          w_state_nxt  = S_HUNT;
          w_idx_nxt    = 6'd0;
        end else begin
          w_idx_nxt = r_idx + 6'd1;
          w_shift   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_HUNT;
      r_idx        <= 6'd0;
      r_cnt        <= 3'd0;
      r_sr         <= '0;
      r_b57        <= 1'b0;
      load_o       <= 1'b0;
      frame_err_o  <= 1'b0;
      synced_o     <= 1'b0;
      min_units_o  <= '0;
      min_tens_o   <= '0;
      hour_units_o <= '0;
      hour_tens_o  <= '0;
`ifdef MSF_DATE_EN
      r_b_date     <= '0;
      year_o       <= '0;
      month_o      <= '0;
      day_o        <= '0;
      weekday_o    <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      load_o      <= w_load_nxt;
      frame_err_o <= w_err_nxt;
      synced_o    <= w_synced_nxt;
      if (w_shift) begin
        r_sr <= {r_sr[57:0], bit_a_i};
        if (w_idx_nxt == 6'd57) r_b57 <= bit_b_i;
`ifdef MSF_DATE_EN
        case (w_idx_nxt)
          6'd54:   r_b_date[0] <= bit_b_i;
          6'd55:   r_b_date[1] <= bit_b_i;
          6'd56:   r_b_date[2] <= bit_b_i;
          default: ;
        endcase
`endif
      end
      if (w_load_nxt) begin
        min_units_o  <= w_mu;
        min_tens_o   <= w_mt;
        hour_units_o <= w_hu;
        hour_tens_o  <= w_ht;
`ifdef MSF_DATE_EN
        year_o       <= w_yr;
        month_o      <= w_mo;
        day_o        <= w_dy;
        weekday_o    <= w_wd;
`endif
      end
    end
  end

endmodule

// File: tb/tb_msf_frame_decoder.sv
// Bench for msf_frame_decoder: two instances (SYNC_FRAMES 1 and 2) checked every cycle against a frame-level model.
module tb_msf_frame_decoder;

  logic clk = 1'b0, rst = 1'b1;
  logic sec_valid = 1'b0, marker = 1'b0, bit_a = 1'b0, bit_b = 1'b0;
  logic [1:0]      load_v, err_v, sync_v;
  logic [1:0][3:0] mu_v, hu_v;
  logic [1:0][2:0] mt_v;
  logic [1:0][1:0] ht_v;
`ifdef MSF_DATE_EN
  logic [1:0][7:0] yr_v;
  logic [1:0][4:0] mo_v;
  logic [1:0][5:0] dy_v;
  logic [1:0][2:0] wd_v;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    msf_frame_decoder #(.SYNC_FRAMES(g + 1)) u_dut (
      .clk_i(clk), .rst_i(rst), .sec_valid_i(sec_valid), .marker_i(marker),
      .bit_a_i(bit_a), .bit_b_i(bit_b), .load_o(load_v[g]),
      .min_units_o(mu_v[g]), .min_tens_o(mt_v[g]), .hour_units_o(hu_v[g]),
      .hour_tens_o(ht_v[g]), .frame_err_o(err_v[g]), .synced_o(sync_v[g])
`ifdef MSF_DATE_EN
      , .year_o(yr_v[g]), .month_o(mo_v[g]), .day_o(dy_v[g]), .weekday_o(wd_v[g])
`endif
    );
  end

  int n_assert = 0, n_fail = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [sync=%0d] t=%0t: got %0d expected %0d", nm, k + 1, $time, act, exp);
    end
  endtask

  // Model: symbols since the last marker kept as arrays indexed by second number.
  bit ma[60], mb[60];
  bit hunting;
  int nsec;
  int sc[2];
  bit e_load[2], e_sync[2], e_err;
  int e_ht[2], e_hu[2], e_mt[2], e_mu[2], e_yr[2], e_mo[2], e_dy[2], e_wd[2];

  function automatic int ones(input bit a[60], input int first, input int last);
    int n = 0;
    for (int i = first; i <= last; i++) n += int'(a[i]);
    return n;
  endfunction

  function automatic int fld(input int first, input int last);
    int v = 0;
    for (int i = first; i <= last; i++) v = v * 2 + int'(ma[i]);
    return v;
  endfunction

  function automatic bit frame_ok();
    int idp[8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    int ht, hu, mt, mu;
    for (int i = 0; i < 8; i++) if (int'(ma[52 + i]) != idp[i]) return 0;
    if ((ones(ma, 39, 51) + int'(mb[57])) % 2 != 1) return 0;
    ht = fld(39, 40); hu = fld(41, 44); mt = fld(45, 47); mu = fld(48, 51);
    if (hu > 9 || mt > 5 || mu > 9 || ht * 10 + hu > 23) return 0;
`ifdef MSF_DATE_EN
    if ((ones(ma, 17, 24) + int'(mb[54])) % 2 != 1) return 0;
    if ((ones(ma, 25, 35) + int'(mb[55])) % 2 != 1) return 0;
    if ((ones(ma, 36, 38) + int'(mb[56])) % 2 != 1) return 0;
    if (fld(17, 20) > 9 || fld(21, 24) > 9) return 0;
    if (fld(26, 29) > 9 || fld(25, 25) * 10 + fld(26, 29) < 1 || fld(25, 25) * 10 + fld(26, 29) > 12) return 0;
    if (fld(32, 35) > 9 || fld(30, 31) * 10 + fld(32, 35) < 1 || fld(30, 31) * 10 + fld(32, 35) > 31) return 0;
    if (fld(36, 38) > 6) return 0;
`endif
    return 1;
  endfunction

  function automatic void model_reset();
    hunting = 1; nsec = 0; e_err = 0;
    for (int k = 0; k < 2; k++) begin
      sc[k] = 0; e_load[k] = 0; e_sync[k] = 0;
      e_ht[k] = 0; e_hu[k] = 0; e_mt[k] = 0; e_mu[k] = 0;
      e_yr[k] = 0; e_mo[k] = 0; e_dy[k] = 0; e_wd[k] = 0;
    end
  endfunction

  function automatic void model_step();
    bit ok;
    e_err = 0; e_load[0] = 0; e_load[1] = 0;
    if (!sec_valid) return;
    if (marker) begin
      if (!hunting) begin
        ok = (nsec == 59) && frame_ok();
        if (!ok) e_err = 1;
        for (int k = 0; k < 2; k++) begin
          if (ok) begin
            sc[k] = (sc[k] < 7) ? sc[k] + 1 : 7;
            e_sync[k] = (sc[k] >= k + 1);
            if (e_sync[k]) begin
              e_load[k] = 1;
              e_ht[k] = fld(39, 40); e_hu[k] = fld(41, 44); e_mt[k] = fld(45, 47); e_mu[k] = fld(48, 51);
              e_yr[k] = fld(17, 24); e_mo[k] = fld(25, 29); e_dy[k] = fld(30, 35); e_wd[k] = fld(36, 38);
            end
          end else begin
            sc[k] = 0; e_sync[k] = 0;
          end
        end
      end
      hunting = 0; nsec = 0;
    end else if (!hunting) begin
      if (nsec == 59) begin
        e_err = 1; hunting = 1;
        for (int k = 0; k < 2; k++) begin sc[k] = 0; e_sync[k] = 0; end
      end else begin
        nsec++; ma[nsec] = bit_a; mb[nsec] = bit_b;
      end
    end
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("load", k, 32'(load_v[k]), 32'(e_load[k]));
      chk("frame_err", k, 32'(err_v[k]), 32'(e_err));
      chk("synced", k, 32'(sync_v[k]), 32'(e_sync[k]));
      chk("hour_tens", k, 32'(ht_v[k]), e_ht[k]);
      chk("hour_units", k, 32'(hu_v[k]), e_hu[k]);
      chk("min_tens", k, 32'(mt_v[k]), e_mt[k]);
      chk("min_units", k, 32'(mu_v[k]), e_mu[k]);
`ifdef MSF_DATE_EN
      chk("year", k, 32'(yr_v[k]), e_yr[k]);
      chk("month", k, 32'(mo_v[k]), e_mo[k]);
      chk("day", k, 32'(dy_v[k]), e_dy[k]);
      chk("weekday", k, 32'(wd_v[k]), e_wd[k]);
`endif
    end
  end

  // Stimulus frame under construction, indexed by second number.
  bit fa[60], fb[60];

  task automatic put(input int first, input int last, input int val);
    for (int i = last; i >= first; i--) begin
      fa[i] = bit'(val & 1);
      val = val >> 1;
    end
  endtask

  task automatic build_frame(input int hh, input int mm);
    for (int i = 1; i < 60; i++) begin fa[i] = 1'($urandom); fb[i] = 1'($urandom); end
    put(17, 24, 'h25); put(25, 29, 'h06); put(30, 35, 'h15); put(36, 38, 3);
    put(39, 40, hh / 10); put(41, 44, hh % 10); put(45, 47, mm / 10); put(48, 51, mm % 10);
    put(52, 59, 'b0111_1110);
    fb[54] = (ones(fa, 17, 24) % 2 == 0);
    fb[55] = (ones(fa, 25, 35) % 2 == 0);
    fb[56] = (ones(fa, 36, 38) % 2 == 0);
    fb[57] = (ones(fa, 39, 51) % 2 == 0);
  endtask

  task automatic cycle(input bit v, input bit m, input bit a, input bit b);
    sec_valid = v; marker = m; bit_a = a; bit_b = b;
    @(posedge clk);
    model_step();
    #1;
    sec_valid = 0; marker = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 1'($urandom), 1'($urandom));
  endtask

  task automatic send_data(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      idle(int'($urandom_range(0, 2)));
      cycle(1, 0, fa[i], fb[i]);
    end
  endtask

  task automatic send_marker();
    cycle(1, 1, 1'($urandom), 1'($urandom));
  endtask

  task automatic chk_digits(input string nm, input int k, input int ht, input int hu, input int mt, input int mu);
    chk({nm, "_hour_tens"}, k, 32'(ht_v[k]), ht);
    chk({nm, "_hour_units"}, k, 32'(hu_v[k]), hu);
    chk({nm, "_min_tens"}, k, 32'(mt_v[k]), mt);
    chk({nm, "_min_units"}, k, 32'(mu_v[k]), mu);
    chk({nm, "_model_hour"}, k, e_ht[k] * 10 + e_hu[k], ht * 10 + hu);
    chk({nm, "_model_min"}, k, e_mt[k] * 10 + e_mu[k], mt * 10 + mu);
  endtask

  task automatic chk_all_zero(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk({nm, "_load"}, k, 32'(load_v[k]), 0);
      chk({nm, "_err"}, k, 32'(err_v[k]), 0);
      chk({nm, "_synced"}, k, 32'(sync_v[k]), 0);
      chk_digits(nm, k, 0, 0, 0, 0);
    end
  endtask

  initial begin
    int mode, hh, mm, p;
    model_reset();
    #3;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 0;
    idle(3);

    send_marker();
    chk("hunt_marker_load", 0, 32'(load_v[0]), 0);
    chk("hunt_marker_err", 0, 32'(err_v[0]), 0);

    build_frame(14, 37);
    send_data(1, 59); send_marker();
    chk("f1437_load", 0, 32'(load_v[0]), 1);
    chk("f1437_synced", 0, 32'(sync_v[0]), 1);
    chk("f1437_sync2_load", 1, 32'(load_v[1]), 0);
    chk_digits("f1437", 0, 1, 4, 3, 7);
    idle(1);
    chk("load_one_cycle", 0, 32'(load_v[0]), 0);

    build_frame(14, 37); fb[57] = ~fb[57];
    send_data(1, 59); send_marker();
    chk("b57_err", 0, 32'(err_v[0]), 1);
    chk("b57_load", 0, 32'(load_v[0]), 0);
    chk("b57_synced", 0, 32'(sync_v[0]), 0);
    chk_digits("b57_hold", 0, 1, 4, 3, 7);

    build_frame(12, 5);
    send_data(1, 40); send_marker();
    chk("short_err", 0, 32'(err_v[0]), 1);
    send_data(1, 59); send_marker();
    chk("after_short_load", 0, 32'(load_v[0]), 1);
    chk_digits("after_short", 0, 1, 2, 0, 5);

    build_frame(23, 59);
    send_data(1, 59); cycle(1, 0, 1'b0, 1'b0);
    chk("sec60_err", 0, 32'(err_v[0]), 1);
    chk("sec60_synced", 0, 32'(sync_v[0]), 0);
    send_data(1, 59); send_marker();
    chk("hunt_ignore_load", 0, 32'(load_v[0]), 0);
    chk("hunt_ignore_err", 0, 32'(err_v[0]), 0);
    send_data(1, 59); send_marker();
    chk("f2359_load", 0, 32'(load_v[0]), 1);
    chk_digits("f2359", 0, 2, 3, 5, 9);

    send_data(1, 10); send_marker();
    chk("resync_err", 1, 32'(err_v[1]), 1);
    build_frame(9, 59);
    send_data(1, 59); send_marker();
    chk("f0959_sync2_load", 1, 32'(load_v[1]), 0);
    chk("f0959_sync2_synced", 1, 32'(sync_v[1]), 0);
    chk("f0959_sync1_load", 0, 32'(load_v[0]), 1);
    build_frame(10, 0);
    send_data(1, 59); send_marker();
    chk("f1000_sync2_load", 1, 32'(load_v[1]), 1);
    chk("f1000_sync2_synced", 1, 32'(sync_v[1]), 1);
    chk_digits("f1000", 1, 1, 0, 0, 0);

    build_frame(24, 0);
    send_data(1, 59); send_marker();
    chk("hour24_err", 0, 32'(err_v[0]), 1);

    build_frame(7, 45);
    send_marker(); send_data(1, 30);
    rst = 1; model_reset();
    #1;
    chk_all_zero("midreset");
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    send_data(31, 59); send_marker();
    chk("post_reset_load", 0, 32'(load_v[0]), 0);
    chk("post_reset_err", 0, 32'(err_v[0]), 0);
    send_data(1, 59); send_marker();
    chk("post_reset_decode", 0, 32'(load_v[0]), 1);
    chk_digits("post_reset", 0, 0, 7, 4, 5);

    for (int it = 0; it < 16; it++) begin
      mode = int'($urandom_range(0, 5));
      hh = int'($urandom_range(0, 29));
      mm = int'($urandom_range(0, 59));
      build_frame(hh, mm);
      if (mode == 0) begin p = int'($urandom_range(1, 59)); fa[p] = ~fa[p]; end
      if (mode == 1) fb[57] = ~fb[57];
      if (mode == 2) send_data(1, int'($urandom_range(20, 58)));
      else if (mode == 3) begin send_data(1, 59); send_data(1, 1); idle(2); end
      else send_data(1, 59);
      send_marker();
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/msf_frame_decoder.md
# msf_frame_decoder

Collects the per-second MSF symbols for one minute frame, validates it, and emits a single load strobe with the decoded BCD time for the clock's digit counters. Sits between the carrier pulse-width classifier, which supplies one symbol per second, and the hours/minutes digit chain, which consumes `load_o` and the digit values. The decoded time applies to the minute that begins at the marker ending the frame.

## Interface
- `SYNC_FRAMES`, default 1: number of consecutive valid frames required before `load_o` fires; range 1–7.
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `sec_valid_i`  in  1  one-cycle strobe; one symbol received.
- `marker_i`  in  1  symbol is the minute marker (second 0); qualified by `sec_valid_i`.
- `bit_a_i`  in  1  A bit of the current second.
- `bit_b_i`  in  1  B bit of the current second.
- `load_o`  out  1  one-cycle strobe; digit values valid.
- `min_units_o`  out  4  BCD, 0–9.
- `min_tens_o`  out  3  BCD, 0–5.
- `hour_units_o`  out  4  BCD, 0–9.
- `hour_tens_o`  out  2  BCD, 0–2.
- `frame_err_o`  out  1  one-cycle strobe; frame rejected.
- `synced_o`  out  1  level; the last frame was valid and the sync count was met.

## Operation
- States:
  - HUNT: ignore symbols until a marker arrives.
  - COLLECT: count seconds and store bits.
- Second index: 6-bit, 0–59. The marker sets the index to 0. Each non-marker `sec_valid_i` increments the index, stores A into a 59-bit shift register, and stores B when the index is 54–57.
- `marker_i` takes priority over A/B. A/B are ignored on a marker strobe.
- On a marker in COLLECT:
  - If the index is 59, validate the frame:
    - Identifier: A52..A59 = 0,1,1,1,1,1,1,0.
    - Odd parity over A39–A51 plus B57.
    - BCD fields in range, and hour ≤ 23.
  - If the index is not 59, or any check fails: pulse `frame_err_o`, clear the sync count, deassert `synced_o`, restart COLLECT at index 0.
  - If valid: increment the saturating 3-bit sync count. When the count ≥ SYNC_FRAMES, pulse `load_o` and set `synced_o`.
  - Stay in COLLECT at index 0 in every case.
- Field positions (MSB first):
  - Hour tens A39–A40.
  - Hour units A41–A44.
  - Minute tens A45–A47.
  - Minute units A48–A51.
- Data symbol at index 59 (60th data second without a marker): pulse `frame_err_o`, clear the sync count, deassert `synced_o`, go to HUNT.
- A marker in HUNT enters COLLECT at index 0 with no error and no load.
- Digit outputs are registered and hold their value until the next `load_o`.

## Timing
- Reset value of every output is 0; the state resets to HUNT, the index and sync count to 0.
- `load_o`, `frame_err_o`, and the digit outputs are registered, asserting the cycle after the marker `sec_valid_i`.
- Latency is exactly 1 cycle from the marker strobe; the digit outputs change in the same cycle `load_o` asserts.
- `load_o` and `frame_err_o` are never asserted together.
- Back-to-back `sec_valid_i` on consecutive cycles is supported with no lost symbols.
- Reset mid-frame discards all collected bits; decoding resumes only after the next marker.

## Configuration
- `MSF_DATE_EN` defined:
  - Adds outputs `year_o[7:0]` (A17–24), `month_o[4:0]` (A25–29), `day_o[5:0]` (A30–35), `weekday_o[2:0]` (A36–38), all BCD. They are registered with, and update alongside, the time outputs.
  - Adds parity checks A17–24+B54, A25–35+B55, A36–38+B56.
  - Adds range checks: month 01–12, day 01–31, weekday 0–6.
- Not defined: the date ports do not exist, B54–B56 are not stored, and only the time checks apply.

## Test plan
- SYNC_FRAMES=1: marker, then a valid 59-second frame encoding 14:37, then a marker → `load_o`=1 for one cycle after the marker, with hour_tens=1, hour_units=4, min_tens=3, min_units=7, `synced_o`=1.
- Same frame with B57 inverted → `frame_err_o` pulse, no `load_o`, `synced_o`=0, digit outputs hold their previous values.
- Marker after only 40 data seconds → `frame_err_o` pulse, the next frame decodes normally from index 0.
- 60 data seconds with no marker → `frame_err_o` on the 60th, HUNT; subsequent symbols are ignored until a marker.
- SYNC_FRAMES=2: two valid frames 09:59 then 10:00 → no load after the first; `load_o` after the second with hour_tens=1, hour_units=0, min_tens=0, min_units=0.
- `rst_i` pulsed at index 30 → all outputs 0 immediately; the following marker gives no load and no error.
